// File: rtl/mmc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmc_pkg
//  Brief    : Shared types for the multimode game counter. This file holds
//             the step modes, the winning-side encoding and the FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package mmc_pkg;

    // Step selected by up_down
    typedef enum logic [1:0] {
        MODE_UP1 = 2'b00,
        MODE_UP2 = 2'b01,
        MODE_DN1 = 2'b10,
        MODE_DN2 = 2'b11
    } mode_e;

    // Which side ended the game
    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_e;

endpackage : mmc_pkg
`default_nettype wire

// File: rtl/mmc_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : mmc_score_tracker
//  Brief    : Holds two saturating scores, one for the winner flag and one
//             for the loser flag. It reports the cycle in which an increment
//             brings either score to GAME_LIMIT, and which side caused it.
//  Revision : 1.0  initial release
//  Ports    : clk        clock
//             rst        synchronous active-high reset
//             i_clr      synchronous clear of both scores (auto-restart)
//             i_en       scoring enabled (game running)
//             i_winner   registered winner flag of the counter
//             i_loser    registered loser flag of the counter
//             o_hit      an increment reaches GAME_LIMIT this cycle
//             o_who_nxt  side responsible for o_hit (who_e encoding)
// ============================================================================
module mmc_score_tracker
    import mmc_pkg::*;
#(
    parameter int SCORE_W    = 4,
    parameter int GAME_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_winner,
    input  logic       i_loser,
    output logic       o_hit,
    output logic [1:0] o_who_nxt
);

    localparam logic [SCORE_W-1:0] C_LIMIT = SCORE_W'(GAME_LIMIT);
    localparam logic [SCORE_W-1:0] C_LAST  = SCORE_W'(GAME_LIMIT - 1);

    logic [SCORE_W-1:0] r_win_score;
    logic [SCORE_W-1:0] r_lose_score;
    logic               w_win_inc;
    logic               w_lose_inc;
    logic               w_win_hit;
    logic               w_lose_hit;

    // Scores stop at the limit rather than wrapping
    assign w_win_inc  = i_en && i_winner && (r_win_score  != C_LIMIT);
    assign w_lose_inc = i_en && i_loser  && (r_lose_score != C_LIMIT);

    assign w_win_hit  = w_win_inc  && (r_win_score  == C_LAST);
    assign w_lose_hit = w_lose_inc && (r_lose_score == C_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_win_score  <= '0;
            r_lose_score <= '0;
        end else begin
            if (w_win_inc) begin
                r_win_score <= r_win_score + SCORE_W'(1);
            end
            if (w_lose_inc) begin
                r_lose_score <= r_lose_score + SCORE_W'(1);
            end
        end
    end

    // The flags are mutually exclusive, so at most one hit can occur per edge
    assign o_hit     = w_win_hit || w_lose_hit;
    assign o_who_nxt = w_win_hit  ? WHO_WINNER :
                       w_lose_hit ? WHO_LOSER  : WHO_NONE;

endmodule : mmc_score_tracker
`default_nettype wire

// File: rtl/multimode_game_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multimode_game_counter
//  Brief    : Loadable wrapping counter with a step of +1, +2, -1 or -2.
//             It flags all-ones as winner and zero as loser, and keeps a
//             score for each flag. When a score reaches GAME_LIMIT the game
//             ends (gameover/who). The counter then freezes until reset.
//             With the MMC_AUTO_RESTART_EN macro defined, the game instead
//             restarts after RESTART_CYCLES clocks.
//  Revision : 1.0  initial release
//  Ports    : clk        clock, all logic on posedge
//             reset      synchronous active-high reset
//             load       load initvalue this cycle
//             initvalue  load value
//             up_down    00 +1, 01 +2, 10 -1, 11 -2
//             counter    registered count
//             winner     registered, counter is all-ones
//             loser      registered, counter is zero
//             gameover   registered, sticky until reset/restart
//             who        00 none, 01 loser side, 10 winner side
//  Macro    : MMC_AUTO_RESTART_EN enables the timed auto-restart out of OVER
// ============================================================================
module multimode_game_counter
    import mmc_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SCORE_W        = 4,
    parameter int GAME_LIMIT     = 15,
    parameter int RESTART_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] initvalue,
    input  logic [1:0]       up_down,
    output logic [WIDTH-1:0] counter,
    output logic             winner,
    output logic             loser,
    output logic             gameover,
    output logic [1:0]       who
);

    generate
        if ((GAME_LIMIT < 1) || (GAME_LIMIT >= (1 << SCORE_W)) || (RESTART_CYCLES < 1)) begin : g_param_check
            $error("multimode_game_counter: invalid parameter set");
        end
    endgenerate

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_counter;
    logic [WIDTH-1:0] w_cnt_step;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_winner;
    logic             r_loser;
    logic             r_gameover;
    logic [1:0]       r_who;
    logic             w_winner_nxt;
    logic             w_loser_nxt;
    logic             w_gameover_nxt;
    logic [1:0]       w_who_nxt;
    logic             w_hit;
    logic [1:0]       w_hit_who;
    logic             w_restart;

    // ------------------------------------------------------------------
    // Restart timer: it is reloaded throughout RUN, so it holds
    // RESTART_CYCLES on entry to OVER. It counts down to zero, and the
    // following clock performs the restart.
    // ------------------------------------------------------------------
`ifdef MMC_AUTO_RESTART_EN
    localparam int             TMR_W      = $clog2(RESTART_CYCLES + 1);
    localparam logic [TMR_W-1:0] C_TMR_LOAD = TMR_W'(RESTART_CYCLES);

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (r_state == ST_RUN) begin
            r_timer <= C_TMR_LOAD;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - TMR_W'(1);
        end
    end

    assign w_restart = (r_state == ST_OVER) && (r_timer == '0);
`else
    assign w_restart = 1'b0;
`endif

    mmc_score_tracker #(
        .SCORE_W    (SCORE_W),
        .GAME_LIMIT (GAME_LIMIT)
    ) u_score (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_restart),
        .i_en      (r_state == ST_RUN),
        .i_winner  (r_winner),
        .i_loser   (r_loser),
        .o_hit     (w_hit),
        .o_who_nxt (w_hit_who)
    );

    // Modulo-2**WIDTH step
    always_comb begin
        w_cnt_step = r_counter;
        case (mode_e'(up_down))
            MODE_UP1: w_cnt_step = r_counter + WIDTH'(1);
            MODE_UP2: w_cnt_step = r_counter + WIDTH'(2);
            MODE_DN1: w_cnt_step = r_counter - WIDTH'(1);
            MODE_DN2: w_cnt_step = r_counter - WIDTH'(2);
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_counter;
        w_winner_nxt   = 1'b0;
        w_loser_nxt    = 1'b0;
        w_gameover_nxt = r_gameover;
        w_who_nxt      = r_who;
        case (r_state)
            ST_RUN: begin
                w_cnt_nxt    = load ? initvalue : w_cnt_step;
                w_winner_nxt = (w_cnt_nxt == '1);
                w_loser_nxt  = (w_cnt_nxt == '0);
                if (w_hit) begin
                    w_state_nxt    = ST_OVER;
                    w_gameover_nxt = 1'b1;
                    w_who_nxt      = w_hit_who;
                end
            end
            ST_OVER: begin
                // Counter frozen and flags held low; only restart leaves OVER
                if (w_restart) begin
                    w_state_nxt    = ST_RUN;
                    w_cnt_nxt      = initvalue;
                    w_gameover_nxt = 1'b0;
                    w_who_nxt      = WHO_NONE;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_counter  <= '0;
            r_winner   <= 1'b0;
            r_loser    <= 1'b0;
            r_gameover <= 1'b0;
            r_who      <= WHO_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_counter  <= w_cnt_nxt;
            r_winner   <= w_winner_nxt;
            r_loser    <= w_loser_nxt;
            r_gameover <= w_gameover_nxt;
            r_who      <= w_who_nxt;
        end
    end

    assign counter  = r_counter;
    assign winner   = r_winner;
    assign loser    = r_loser;
    assign gameover = r_gameover;
    assign who      = r_who;

endmodule : multimode_game_counter
`default_nettype wire

// File: tb/tb_multimode_game_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multimode_game_counter
//  Brief    : Directed self-checking bench for multimode_game_counter.
//             The auto-restart scenario is compiled in only when
//             MMC_AUTO_RESTART_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multimode_game_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] initvalue = 4'h0;
    logic [1:0] up_down = 2'b00;
    logic [3:0] counter;
    logic       winner;
    logic       loser;
    logic       gameover;
    logic [1:0] who;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       ld;
        logic [3:0] init;
        logic [1:0] mode;
        logic [3:0] cnt;
        logic       w;
        logic       l;
    } vec_t;

    multimode_game_counter #(
        .WIDTH          (4),
        .SCORE_W        (4),
        .GAME_LIMIT     (15),
        .RESTART_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .initvalue (initvalue),
        .up_down   (up_down),
        .counter   (counter),
        .winner    (winner),
        .loser     (loser),
        .gameover  (gameover),
        .who       (who)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; initvalue = 4'h0; up_down = 2'b00;
        tick(); tick();
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL reset_counter: got %h expected %h", counter, 4'h0); end
        n_checks++; if (winner !== 1'b0) begin n_fail++; $display("FAIL reset_winner: got %b expected 0", winner); end
        n_checks++; if (loser !== 1'b0) begin n_fail++; $display("FAIL reset_loser: got %b expected 0", loser); end
        n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL reset_gameover: got %b expected 0", gameover); end
        n_checks++; if (who !== 2'b00) begin n_fail++; $display("FAIL reset_who: got %b expected 00", who); end
        load = 1'b1; initvalue = 4'hF;
        tick();
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL reset_over_load_counter: got %h expected %h", counter, 4'h0); end
        n_checks++; if (winner !== 1'b0) begin n_fail++; $display("FAIL reset_over_load_winner: got %b expected 0", winner); end
        load = 1'b0;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_cnt [4];
        logic       exp_w   [4];
        logic       exp_l   [4];
        exp_cnt = '{4'hD, 4'hE, 4'hF, 4'h0};
        exp_w   = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_l   = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load = 1'b1; initvalue = 4'hC;
        tick();
        n_checks++; if (counter !== 4'hC) begin n_fail++; $display("FAIL up_load_counter: got %h expected %h", counter, 4'hC); end
        load = 1'b0; up_down = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (counter !== exp_cnt[i]) begin n_fail++; $display("FAIL up_counter[%0d]: got %h expected %h", i, counter, exp_cnt[i]); end
            n_checks++; if (winner !== exp_w[i]) begin n_fail++; $display("FAIL up_winner[%0d]: got %b expected %b", i, winner, exp_w[i]); end
            n_checks++; if (loser !== exp_l[i]) begin n_fail++; $display("FAIL up_loser[%0d]: got %b expected %b", i, loser, exp_l[i]); end
        end
    endtask

    task automatic test_modes();
        vec_t tbl [15];
        tbl = '{
            '{1'b1, 4'h6, 2'b00, 4'h6, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'h8, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'hA, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'hC, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'hE, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'h0, 1'b0, 1'b1},
            '{1'b1, 4'h1, 2'b00, 4'h1, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b10, 4'h0, 1'b0, 1'b1},
            '{1'b0, 4'h0, 2'b10, 4'hF, 1'b1, 1'b0},
            '{1'b0, 4'h0, 2'b11, 4'hD, 1'b0, 1'b0},
            '{1'b1, 4'h1, 2'b00, 4'h1, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b11, 4'hF, 1'b1, 1'b0},
            '{1'b1, 4'hF, 2'b00, 4'hF, 1'b1, 1'b0},
            '{1'b0, 4'h0, 2'b01, 4'h1, 1'b0, 1'b0},
            '{1'b0, 4'h0, 2'b10, 4'h0, 1'b0, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 15; i++) begin
            load = tbl[i].ld; initvalue = tbl[i].init; up_down = tbl[i].mode;
            tick();
            n_checks++; if (counter !== tbl[i].cnt) begin n_fail++; $display("FAIL modes_counter[%0d]: got %h expected %h", i, counter, tbl[i].cnt); end
            n_checks++; if (winner !== tbl[i].w) begin n_fail++; $display("FAIL modes_winner[%0d]: got %b expected %b", i, winner, tbl[i].w); end
            n_checks++; if (loser !== tbl[i].l) begin n_fail++; $display("FAIL modes_loser[%0d]: got %b expected %b", i, loser, tbl[i].l); end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [6];
        vals = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
        do_reset();
        load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            initvalue = vals[i];
            tick();
            n_checks++; if (counter !== vals[i]) begin n_fail++; $display("FAIL b2b_counter[%0d]: got %h expected %h", i, counter, vals[i]); end
            n_checks++; if (winner !== (vals[i] == 4'hF)) begin n_fail++; $display("FAIL b2b_winner[%0d]: got %b expected %b", i, winner, vals[i] == 4'hF); end
            n_checks++; if (loser !== (vals[i] == 4'h0)) begin n_fail++; $display("FAIL b2b_loser[%0d]: got %b expected %b", i, loser, vals[i] == 4'h0); end
        end
        load = 1'b0;
    endtask

    task automatic test_win_game();
        do_reset();
        up_down = 2'b00;
        for (int i = 0; i < 15; i++) begin
            load = 1'b1; initvalue = 4'hE;
            tick();
            n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL win_early_gameover[%0d]: got %b expected 0", i, gameover); end
            load = 1'b0;
            tick();
            n_checks++; if (winner !== 1'b1) begin n_fail++; $display("FAIL win_event[%0d]: got %b expected 1", i, winner); end
        end
        // Fifteenth winner cycle is scored on this edge: F+1 wraps to 0
        tick();
        n_checks++; if (gameover !== 1'b1) begin n_fail++; $display("FAIL win_gameover: got %b expected 1", gameover); end
        n_checks++; if (who !== 2'b10) begin n_fail++; $display("FAIL win_who: got %b expected 10", who); end
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL win_last_counter: got %h expected %h", counter, 4'h0); end
        tick();
        n_checks++; if (loser !== 1'b0) begin n_fail++; $display("FAIL win_over_loser_forced: got %b expected 0", loser); end
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL win_over_frozen: got %h expected %h", counter, 4'h0); end
        load = 1'b1; initvalue = 4'h3; up_down = 2'b01;
        tick();
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL win_over_load_ignored: got %h expected %h", counter, 4'h0); end
        n_checks++; if (gameover !== 1'b1) begin n_fail++; $display("FAIL win_over_gameover_held: got %b expected 1", gameover); end
        n_checks++; if (who !== 2'b10) begin n_fail++; $display("FAIL win_over_who_held: got %b expected 10", who); end
        load = 1'b0; up_down = 2'b00;
    endtask

    task automatic test_lose_game();
        int n_lose;
        n_lose = 0;
        do_reset();
        load = 1'b1; initvalue = 4'h2;
        tick();
        load = 1'b0; up_down = 2'b11;
        // 2,0,E,...: loser every 8 steps, the 15th at step 113
        for (int j = 1; j <= 113; j++) begin
            tick();
            if (loser === 1'b1) n_lose++;
        end
        n_checks++; if (n_lose != 15) begin n_fail++; $display("FAIL lose_event_count: got %0d expected 15", n_lose); end
        n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL lose_early_gameover: got %b expected 0", gameover); end
        tick();
        n_checks++; if (gameover !== 1'b1) begin n_fail++; $display("FAIL lose_gameover: got %b expected 1", gameover); end
        n_checks++; if (who !== 2'b01) begin n_fail++; $display("FAIL lose_who: got %b expected 01", who); end
        n_checks++; if (counter !== 4'hE) begin n_fail++; $display("FAIL lose_last_counter: got %h expected %h", counter, 4'hE); end
        tick();
        n_checks++; if (counter !== 4'hE) begin n_fail++; $display("FAIL lose_over_frozen: got %h expected %h", counter, 4'hE); end
        reset = 1'b1; load = 1'b1; initvalue = 4'h5;
        tick();
        n_checks++; if (counter !== 4'h0) begin n_fail++; $display("FAIL midover_reset_counter: got %h expected %h", counter, 4'h0); end
        n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL midover_reset_gameover: got %b expected 0", gameover); end
        n_checks++; if (who !== 2'b00) begin n_fail++; $display("FAIL midover_reset_who: got %b expected 00", who); end
        n_checks++; if ((winner | loser) !== 1'b0) begin n_fail++; $display("FAIL midover_reset_flags: got %b%b expected 00", winner, loser); end
        reset = 1'b0;
        tick();
        n_checks++; if (counter !== 4'h5) begin n_fail++; $display("FAIL after_reset_load: got %h expected %h", counter, 4'h5); end
        load = 1'b0; up_down = 2'b00;
    endtask

`ifdef MMC_AUTO_RESTART_EN
    task automatic test_auto_restart();
        do_reset();
        up_down = 2'b00;
        for (int i = 0; i < 15; i++) begin
            load = 1'b1; initvalue = 4'hE;
            tick();
            load = 1'b0;
            tick();
        end
        initvalue = 4'h7;
        tick();
        n_checks++; if (gameover !== 1'b1) begin n_fail++; $display("FAIL ar_gameover_rise: got %b expected 1", gameover); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++; if (gameover !== 1'b1) begin n_fail++; $display("FAIL ar_gameover_hold[%0d]: got %b expected 1", k, gameover); end
        end
        tick();
        n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL ar_gameover_clear: got %b expected 0", gameover); end
        n_checks++; if (who !== 2'b00) begin n_fail++; $display("FAIL ar_who_clear: got %b expected 00", who); end
        n_checks++; if (counter !== 4'h7) begin n_fail++; $display("FAIL ar_counter_init: got %h expected %h", counter, 4'h7); end
        tick();
        n_checks++; if (counter !== 4'h8) begin n_fail++; $display("FAIL ar_counting_resumed: got %h expected %h", counter, 4'h8); end
        // Scores were cleared: a single new winner event must not end the game
        load = 1'b1; initvalue = 4'hF;
        tick();
        load = 1'b0;
        tick(); tick();
        n_checks++; if (gameover !== 1'b0) begin n_fail++; $display("FAIL ar_scores_cleared: got %b expected 0", gameover); end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_modes();
        test_back_to_back();
        test_win_game();
        test_lose_game();
`ifdef MMC_AUTO_RESTART_EN
        test_auto_restart();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multimode_game_counter
`default_nettype wire
